seg7_glyph_capture: RTL and testbench

//  Receive side of the seven-segment display path. Samples an active-high
//  7-segment bus (a=bit0 .. g=bit6), waits until the pattern is stable, and

---
 rtl/seg7_pkg.sv | 63 ++++++
 rtl/seg7_glyph_capture_if.sv | 29 ++
 rtl/glyph_fifo.sv | 70 +++++++
 rtl/seg7_glyph_capture.sv | 78 +++++++
 tb/tb_seg7_glyph_capture.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared types, segment pattern constants, glyph codes and the pattern decoder
// for the seven-segment glyph capture path. Segment order is {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [4:0] code_t;

  localparam seg_t SEG_BLANK = 7'h00;
  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_A     = 7'h77;
  localparam seg_t SEG_B     = 7'h7C;
  localparam seg_t SEG_C     = 7'h39;
  localparam seg_t SEG_D     = 7'h5E;
  localparam seg_t SEG_E     = 7'h79;
  localparam seg_t SEG_F     = 7'h71;
  localparam seg_t SEG_G     = 7'h3D;
  localparam seg_t SEG_R     = 7'h50;
  localparam seg_t SEG_Y     = 7'h6E;

  localparam code_t CODE_G   = 5'd16;
  localparam code_t CODE_R   = 5'd17;
  localparam code_t CODE_Y   = 5'd18;
  localparam code_t CODE_BAD = 5'd30;

  // Map a segment pattern to its glyph code; anything unrecognised
  // (including blank, which callers filter out first) yields CODE_BAD.
  function automatic code_t decode(input seg_t s);
    code_t c;
    case (s)
      SEG_0:   c = 5'd0;
      SEG_1:   c = 5'd1;
      SEG_2:   c = 5'd2;
      SEG_3:   c = 5'd3;
      SEG_4:   c = 5'd4;
      SEG_5:   c = 5'd5;
      SEG_6:   c = 5'd6;
      SEG_7:   c = 5'd7;
      SEG_8:   c = 5'd8;
      SEG_9:   c = 5'd9;
      SEG_A:   c = 5'd10;
      SEG_B:   c = 5'd11;
      SEG_C:   c = 5'd12;
      SEG_D:   c = 5'd13;
      SEG_E:   c = 5'd14;
      SEG_F:   c = 5'd15;
      SEG_G:   c = CODE_G;
      SEG_R:   c = CODE_R;
      SEG_Y:   c = CODE_Y;
      default: c = CODE_BAD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/seg7_glyph_capture_if.sv
// Bus between the glyph capture block and its user: segment input and
// capture enable towards the block, FIFO readout and status back.
interface seg7_glyph_capture_if #(
  parameter int FIFO_DEPTH = 8
);
  import seg7_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          ena;
  seg_t          seg_in;
  logic          rd_en;
  code_t         code_out;
  logic          code_valid;
  logic          glyph_err;
  logic          overflow;
  logic [CW-1:0] fifo_count;

  modport master (
    output ena, seg_in, rd_en,
    input  code_out, code_valid, glyph_err, overflow, fifo_count
  );

  modport slave (
    input  ena, seg_in, rd_en,
    output code_out, code_valid, glyph_err, overflow, fifo_count
  );

endinterface

// File: rtl/glyph_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and a sticky
// overflow flag. A pop frees the head slot on the same edge, so a push is
// still taken when full if a pop accompanies it.
module glyph_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             full, empty, do_push, do_pop;

  // Next-state for pointers, count and overflow from the push/pop request.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    full       = (count_q == CW'(DEPTH));
    empty      = (count_q == '0);
    do_pop     = pop_i && !empty;
    do_push    = push_i && (!full || do_pop);
    wr_ptr_d   = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
    overflow_d = overflow_q || (push_i && !do_push);
  end

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; empty reads are masked below.
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Pointer, count and sticky-overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign rd_data_o  = empty ? '0 : mem_q[rd_ptr_q];
  assign valid_o    = !empty;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/seg7_glyph_capture.sv
// Observer for a seven-segment display bus: synchronises the asynchronous
// segment lines, waits for the pattern to be stable, decodes each newly
// accepted glyph and queues it in a FWFT FIFO for readout.
module seg7_glyph_capture
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg7_glyph_capture_if.slave   bus
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  seg_t             sync1_q, sync2_q, prev_q;
  seg_t             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             glyph_err_q, glyph_err_d;
  logic             same, accept, new_glyph, push;
  code_t            push_code;

  // Stability counting and accept decision on the synchronised pattern.
  always_comb begin
    same        = (sync2_q == prev_q);
    cnt_d       = cnt_q;
    if (!bus.ena || !same)    cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    // The accept edge is the one on which the counter reaches its limit.
    accept      = bus.ena && same && (cnt_q == CNT_LAST);
    new_glyph   = accept && (sync2_q != last_q);
    last_d      = new_glyph ? sync2_q : last_q;
    push        = new_glyph && (sync2_q != SEG_BLANK);
    push_code   = decode(sync2_q);
    glyph_err_d = push && (push_code == CODE_BAD);
  end

  // Two-flop synchroniser, previous-sample register, counter and accept state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= SEG_BLANK;
      sync2_q     <= SEG_BLANK;
      prev_q      <= SEG_BLANK;
      last_q      <= SEG_BLANK;
      cnt_q       <= '0;
      glyph_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the pre-edge values.
      sync1_q     <= bus.seg_in;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      glyph_err_q <= glyph_err_d;
    end
  end

  glyph_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (5)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (push_code),
    .pop_i       (bus.rd_en),
    .rd_data_o   (bus.code_out),
    .valid_o     (bus.code_valid),
    .count_o     (bus.fifo_count),
    .overflow_o  (bus.overflow)
  );

  assign bus.glyph_err = glyph_err_q;

endmodule

// File: tb/tb_seg7_glyph_capture.sv
// Self-checking bench for seg7_glyph_capture: directed scenarios plus
// randomised pattern streams scored against a run-length reference model.
module tb_seg7_glyph_capture;

  localparam int STABLE = 4;
  localparam int DEPTH  = 8;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   err_seen     = 0;

  // Glyph table: the code of a pattern is its index here.
  logic [6:0] glyph_pat [19] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D,
                                 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E,
                                 7'h79, 7'h71, 7'h3D, 7'h50, 7'h6E};

  always #5 clk = ~clk;

  seg7_glyph_capture_if #(.FIFO_DEPTH(DEPTH)) bus ();

  seg7_glyph_capture #(
    .STABLE_CYCLES (STABLE),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Count error pulses, sampled mid-cycle.
  always @(negedge clk) if (bus.glyph_err === 1'b1) err_seen++;

  function automatic logic [4:0] model_code(input logic [6:0] p);
    for (int i = 0; i < 19; i++) if (glyph_pat[i] == p) return 5'(i);
    return 5'd30;
  endfunction

  task automatic hold(input logic [6:0] p, input int n);
    for (int i = 0; i < n; i++) begin
      bus.seg_in = p;
      @(negedge clk);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; bus.seg_in = 7'h00; bus.rd_en = 1'b0; bus.ena = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Pop every expected code in order, then require the FIFO empty.
  task automatic drain(input string name, input logic [4:0] exp_q[$]);
    foreach (exp_q[i]) begin
      tests_run++;
      if (bus.code_valid !== 1'b1 || bus.code_out !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL %s[%0d]: got code %0d valid %b, expected code %0d valid 1",
                 name, i, bus.code_out, bus.code_valid, exp_q[i]);
      end
      bus.rd_en = 1'b1;
      @(negedge clk);
      bus.rd_en = 1'b0;
    end
    tests_run++;
    if (bus.code_valid !== 1'b0 || bus.fifo_count !== '0) begin
      tests_failed++;
      $display("FAIL %s_empty: got valid %b count %0d, expected 0 0",
               name, bus.code_valid, bus.fifo_count);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.ena = 1'b1; bus.rd_en = 1'b0; bus.seg_in = 7'h3D;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({bus.code_out, bus.code_valid, bus.glyph_err, bus.overflow, bus.fifo_count} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got code %0d valid %b err %b ovf %b count %0d, expected all 0",
               bus.code_out, bus.code_valid, bus.glyph_err, bus.overflow, bus.fifo_count);
    end
    bus.seg_in = 7'h00;
    rst_n = 1'b1;
    hold(7'h00, 8);
    tests_run++;
    if (bus.code_valid !== 1'b0 || bus.fifo_count !== '0) begin
      tests_failed++;
      $display("FAIL reset_blank_idle: got valid %b count %0d, expected 0 0",
               bus.code_valid, bus.fifo_count);
    end
  endtask

  task automatic test_single_glyph();
    logic [4:0] exp_q[$];
    apply_reset();
    for (int e = 1; e <= 10; e++) begin
      bus.seg_in = 7'h3D;
      @(negedge clk);
      tests_run++;
      if (bus.code_valid !== (e >= STABLE + 3)) begin
        tests_failed++;
        $display("FAIL latency_edge%0d: got valid %b, expected %b", e, bus.code_valid, e >= STABLE + 3);
      end
    end
    tests_run++;
    if (bus.fifo_count !== CW'(1)) begin
      tests_failed++;
      $display("FAIL single_count: got %0d, expected 1", bus.fifo_count);
    end
    exp_q.push_back(5'd16);
    drain("single", exp_q);
  endtask

  task automatic test_sequence();
    logic [6:0] seq [8] = '{7'h3D, 7'h00, 7'h79, 7'h00, 7'h50, 7'h00, 7'h50, 7'h00};
    logic [4:0] exp_q[$] = '{5'd16, 5'd14, 5'd17, 5'd17};
    apply_reset();
    foreach (seq[i]) hold(seq[i], 8);
    tests_run++;
    if (bus.fifo_count !== CW'(4)) begin
      tests_failed++;
      $display("FAIL seq_count: got %0d, expected 4", bus.fifo_count);
    end
    drain("seq", exp_q);
  endtask

  task automatic test_toggle();
    logic [4:0] exp_q[$] = '{5'd2};
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      hold(7'h06, 2);
      hold(7'h5B, 2);
    end
    tests_run++;
    if (bus.fifo_count !== '0) begin
      tests_failed++;
      $display("FAIL toggle_no_push: got count %0d, expected 0", bus.fifo_count);
    end
    hold(7'h5B, 10);
    tests_run++;
    if (bus.fifo_count !== CW'(1)) begin
      tests_failed++;
      $display("FAIL toggle_settle_count: got %0d, expected 1", bus.fifo_count);
    end
    drain("toggle", exp_q);
  endtask

  task automatic test_bad_glyph();
    int e0;
    logic [4:0] exp_q[$] = '{5'd30};
    apply_reset();
    e0 = err_seen;
    hold(7'h01, 20);
    tests_run++;
    if (bus.fifo_count !== CW'(1) || (err_seen - e0) != 1) begin
      tests_failed++;
      $display("FAIL bad_glyph: got count %0d err_pulses %0d, expected 1 1",
               bus.fifo_count, err_seen - e0);
    end
    drain("bad", exp_q);
    hold(7'h00, 8);
  endtask

  task automatic test_overflow();
    logic [4:0] exp_q[$] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd10};
    apply_reset();
    for (int i = 0; i < 9; i++) hold(glyph_pat[i], 8);
    tests_run++;
    if (bus.fifo_count !== CW'(8) || bus.overflow !== 1'b1 || bus.code_out !== 5'd0) begin
      tests_failed++;
      $display("FAIL ovf_full: got count %0d ovf %b head %0d, expected 8 1 0",
               bus.fifo_count, bus.overflow, bus.code_out);
    end
    // New glyph 'A' accepted on edge STABLE+3 while popping on that same edge.
    for (int e = 1; e <= STABLE + 3; e++) begin
      bus.seg_in = 7'h77;
      bus.rd_en  = (e == STABLE + 3);
      @(negedge clk);
    end
    bus.rd_en = 1'b0;
    tests_run++;
    if (bus.fifo_count !== CW'(8) || bus.overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_push_pop: got count %0d ovf %b, expected 8 1",
               bus.fifo_count, bus.overflow);
    end
    hold(7'h77, 4);
    drain("ovf", exp_q);
  endtask

  task automatic test_enable();
    logic [4:0] exp_q[$] = '{5'd2};
    apply_reset();
    hold(7'h06, 8);
    bus.ena = 1'b0;
    hold(7'h06, 4);
    hold(7'h5B, 10);
    tests_run++;
    if (bus.fifo_count !== CW'(1)) begin
      tests_failed++;
      $display("FAIL ena_low_idle: got count %0d, expected 1", bus.fifo_count);
    end
    bus.ena = 1'b1;
    hold(7'h5B, 10);
    tests_run++;
    if (bus.fifo_count !== CW'(2) || bus.code_out !== 5'd1) begin
      tests_failed++;
      $display("FAIL ena_resume: got count %0d head %0d, expected 2 1", bus.fifo_count, bus.code_out);
    end
    bus.ena = 1'b0;
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    hold(7'h5B, 5);
    bus.ena = 1'b1;
    hold(7'h5B, 10);
    tests_run++;
    if (bus.fifo_count !== CW'(1)) begin
      tests_failed++;
      $display("FAIL ena_no_requeue: got count %0d, expected 1", bus.fifo_count);
    end
    drain("ena", exp_q);
  endtask

  task automatic test_reset_mid();
    logic [4:0] exp_q[$] = '{5'd9};
    apply_reset();
    hold(7'h3D, 8);
    hold(7'h79, 8);
    hold(7'h50, 8);
    hold(7'h6F, 10);
    tests_run++;
    if (bus.fifo_count !== CW'(4)) begin
      tests_failed++;
      $display("FAIL mid_prefill: got count %0d, expected 4", bus.fifo_count);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.code_out, bus.code_valid, bus.glyph_err, bus.overflow, bus.fifo_count} !== '0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: got code %0d valid %b err %b ovf %b count %0d, expected all 0",
               bus.code_out, bus.code_valid, bus.glyph_err, bus.overflow, bus.fifo_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    hold(7'h6F, 10);
    tests_run++;
    if (bus.fifo_count !== CW'(1)) begin
      tests_failed++;
      $display("FAIL mid_reaccept: got count %0d, expected 1", bus.fifo_count);
    end
    drain("mid", exp_q);
  endtask

  // Random stream of (pattern, hold) pairs; the model merges equal neighbours
  // into runs and accepts a run lasting STABLE+1 cycles if it is a new pattern.
  task automatic test_random(input int round);
    logic [6:0] pats[$];
    int         holds[$];
    logic [4:0] exp_q[$];
    logic [6:0] last, run_p, p;
    logic [4:0] code;
    int         run_len, exp_err, e0, n, sel;
    bit         exp_ovf;
    apply_reset();
    e0 = err_seen;
    pats.push_back(7'h00); holds.push_back(8);
    n = int'($urandom_range(8, 16));
    for (int i = 0; i < n; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 6)      p = glyph_pat[$urandom_range(0, 18)];
      else if (sel < 8) p = 7'h00;
      else              p = 7'($urandom_range(1, 127));
      pats.push_back(p);
      holds.push_back(int'($urandom_range(1, 8)));
    end
    pats.push_back(7'h00); holds.push_back(12);
    foreach (pats[i]) hold(pats[i], holds[i]);

    last = 7'h00; exp_ovf = 1'b0; exp_err = 0;
    run_p = pats[0]; run_len = 0;
    for (int i = 0; i <= pats.size(); i++) begin
      if (i < pats.size() && pats[i] == run_p) begin
        run_len += holds[i];
      end else begin
        if (run_len >= STABLE + 1 && run_p != last) begin
          last = run_p;
          if (run_p != 7'h00) begin
            code = model_code(run_p);
            if (code == 5'd30) exp_err++;
            if (exp_q.size() < DEPTH) exp_q.push_back(code);
            else exp_ovf = 1'b1;
          end
        end
        if (i < pats.size()) begin
          run_p = pats[i];
          run_len = holds[i];
        end
      end
    end

    tests_run++;
    if (bus.fifo_count !== CW'(exp_q.size()) || bus.overflow !== exp_ovf || (err_seen - e0) != exp_err) begin
      tests_failed++;
      $display("FAIL rand%0d_status: got count %0d ovf %b err %0d, expected %0d %b %0d",
               round, bus.fifo_count, bus.overflow, err_seen - e0, exp_q.size(), exp_ovf, exp_err);
    end
    drain($sformatf("rand%0d", round), exp_q);
  endtask

  initial begin
    bus.ena = 1'b1; bus.rd_en = 1'b0; bus.seg_in = 7'h00;
    test_reset();
    test_single_glyph();
    test_sequence();
    test_toggle();
    test_bad_glyph();
    test_overflow();
    test_enable();
    test_reset_mid();
    for (int r = 0; r < 6; r++) test_random(r);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
